serial_mem_responder: RTL



---
 rtl/serial_mem_responder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_mem_responder.sv
// serial_mem_responder: serial-port memory model that answers CPU read/write messages with queued read replies
// Ports: clk, rst_n (async active-low); tx_pins/tx_fetch/tx_jump in from the CPU;
// rx_pins reply lane, queue_level pending reads, overflow and proto_error sticky flags.
// Optional macro SERIAL_MEM_FETCH_STATS_EN adds fetch_count/jump_count outputs.
module serial_mem_responder #(
  parameter int IO_BITS         = 2,
  parameter int PAYLOAD_CYCLES  = 8,
  parameter int ADDR_BITS       = 8,
  parameter int MAX_OUTSTANDING = 7,
  parameter int RESPONSE_DELAY  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [IO_BITS-1:0]                     tx_pins,
  input  logic                                   tx_fetch,
  input  logic                                   tx_jump,
  output logic [IO_BITS-1:0]                     rx_pins,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   queue_level,
  output logic                                   overflow,
  output logic                                   proto_error
`ifdef SERIAL_MEM_FETCH_STATS_EN
  ,
  output logic [15:0]                            fetch_count,
  output logic [15:0]                            jump_count
`endif
);
  localparam int BW = $clog2(PAYLOAD_CYCLES);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int LW = $clog2(MAX_OUTSTANDING+1);
  localparam int AW = $clog2(RESPONSE_DELAY+1);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WDATA} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA} tx_state_t;
  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  logic [BW-1:0] rx_beat_q, rx_beat_d, tx_beat_q, tx_beat_d;
  logic is_write_q, is_write_d, wr_pending_q, wr_pending_d;
  logic [15:0] addr_q, addr_d, data_q, data_d, shift_q, shift_d, word;
  logic [IO_BITS-1:0] rx_pins_q, rx_pins_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic overflow_q, overflow_d, proto_error_q, proto_error_d;
  logic [ADDR_BITS-1:0] qaddr_q [MAX_OUTSTANDING];
  logic [ADDR_BITS-1:0] qaddr_d [MAX_OUTSTANDING];
  logic [AW-1:0] qage_q [MAX_OUTSTANDING];
  logic [AW-1:0] qage_d [MAX_OUTSTANDING];
  logic [ADDR_BITS-1:0] head_addr;
  logic push_req, push, pop;
  logic [15:0] mem [2**ADDR_BITS];
`ifdef SERIAL_MEM_FETCH_STATS_EN
  logic [15:0] fetch_count_q, fetch_count_d, jump_count_q, jump_count_d;
  assign fetch_count = fetch_count_q;
  assign jump_count  = jump_count_q;
`else
  logic unused_flags;
  assign unused_flags = tx_fetch ^ tx_jump;
`endif
  assign rx_pins     = rx_pins_q;
  assign queue_level = level_q;
  assign overflow    = overflow_q;
  assign proto_error = proto_error_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING-1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    rx_state_d    = rx_state_q;
    tx_state_d    = tx_state_q;
    rx_beat_d     = rx_beat_q;
    tx_beat_d     = tx_beat_q;
    is_write_d    = is_write_q;
    wr_pending_d  = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    shift_d       = shift_q;
    rx_pins_d     = '0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    overflow_d    = overflow_q;
    proto_error_d = proto_error_q;
    qaddr_d       = qaddr_q;
    push_req      = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
`ifdef SERIAL_MEM_FETCH_STATS_EN
    fetch_count_d = fetch_count_q;
    jump_count_d  = jump_count_q;
`endif
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      qage_d[i] = qage_q[i] < AW'(RESPONSE_DELAY) ? qage_q[i] + 1'b1 : qage_q[i];
    head_addr = qaddr_q[rd_ptr_q];
    // a write landing in the same cycle as the reply capture is forwarded
    word = (wr_pending_q && addr_q[ADDR_BITS-1:0] == head_addr) ? data_q : mem[head_addr];
    case (rx_state_q)
      R_IDLE: begin
        rx_beat_d     = '0;
        is_write_d    = tx_pins[1];
        rx_state_d    = (tx_pins == IO_BITS'(1) || tx_pins == IO_BITS'(2)) ? R_ADDR : R_IDLE;
        proto_error_d = proto_error_q | (tx_pins == IO_BITS'(3));
`ifdef SERIAL_MEM_FETCH_STATS_EN
        if (tx_pins == IO_BITS'(1) && tx_fetch) begin
          fetch_count_d = fetch_count_q + 16'd1;
          jump_count_d  = tx_jump ? jump_count_q + 16'd1 : jump_count_q;
        end
`endif
      end
      R_ADDR: begin
        addr_d    = {tx_pins, addr_q[15:IO_BITS]};
        rx_beat_d = rx_beat_q + 1'b1;
        if (rx_beat_q == BW'(PAYLOAD_CYCLES-1)) begin
          rx_beat_d  = '0;
          rx_state_d = is_write_q ? R_WDATA : R_IDLE;
          push_req   = !is_write_q;
        end
      end
      R_WDATA: begin
        data_d    = {tx_pins, data_q[15:IO_BITS]};
        rx_beat_d = rx_beat_q + 1'b1;
        if (rx_beat_q == BW'(PAYLOAD_CYCLES-1)) begin
          rx_beat_d    = '0;
          rx_state_d   = R_IDLE;
          wr_pending_d = 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
    case (tx_state_q)
      T_IDLE: begin
        if (level_q != '0 && qage_q[rd_ptr_q] >= AW'(RESPONSE_DELAY)) begin
          tx_state_d = T_START;
          rx_pins_d  = IO_BITS'(1);
        end
      end
      T_START: begin
        tx_state_d = T_DATA;
        tx_beat_d  = '0;
        rx_pins_d  = word[IO_BITS-1:0];
        shift_d    = word >> IO_BITS;
      end
      T_DATA: begin
        tx_beat_d = tx_beat_q + 1'b1;
        rx_pins_d = shift_q[IO_BITS-1:0];
        shift_d   = shift_q >> IO_BITS;
        if (tx_beat_q == BW'(PAYLOAD_CYCLES-1)) begin
          tx_state_d = T_IDLE;
          tx_beat_d  = '0;
          rx_pins_d  = '0;
          pop        = 1'b1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
    // a full queue still accepts a push in the cycle its head is popped
    if (push_req) begin
      overflow_d = overflow_q | (level_q == LW'(MAX_OUTSTANDING) && !pop);
      push       = !(level_q == LW'(MAX_OUTSTANDING) && !pop);
    end
    if (push) begin
      qaddr_d[wr_ptr_q] = addr_d[ADDR_BITS-1:0];
      // the push cycle itself counts toward the reply delay
      qage_d[wr_ptr_q]  = AW'(1);
      wr_ptr_d          = nxt(wr_ptr_q);
    end
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q    <= R_IDLE;
      tx_state_q    <= T_IDLE;
      rx_beat_q     <= '0;
      tx_beat_q     <= '0;
      is_write_q    <= 1'b0;
      wr_pending_q  <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      shift_q       <= '0;
      rx_pins_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      proto_error_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        qaddr_q[i] <= '0;
        qage_q[i]  <= '0;
      end
`ifdef SERIAL_MEM_FETCH_STATS_EN
      fetch_count_q <= '0;
      jump_count_q  <= '0;
`endif
    end else begin
      rx_state_q    <= rx_state_d;
      tx_state_q    <= tx_state_d;
      rx_beat_q     <= rx_beat_d;
      tx_beat_q     <= tx_beat_d;
      is_write_q    <= is_write_d;
      wr_pending_q  <= wr_pending_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      shift_q       <= shift_d;
      rx_pins_q     <= rx_pins_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      proto_error_q <= proto_error_d;
      qaddr_q       <= qaddr_d;
      qage_q        <= qage_d;
`ifdef SERIAL_MEM_FETCH_STATS_EN
      fetch_count_q <= fetch_count_d;
      jump_count_q  <= jump_count_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (wr_pending_q) mem[addr_q[ADDR_BITS-1:0]] <= data_q;
  end
endmodule
